// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and types for the CPU control sequencer.
// Opcode map, microstep/mode encodings and the packed control word.
// CTRL_IDLE is the all-deasserted control word (active-low strobes high).
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_t;

  typedef enum logic {
    MODE_RUN  = 1'b0,
    MODE_HALT = 1'b1
  } mode_t;

  localparam int unsigned NUM_STEPS = 5;

  // Strobes are active-low except alu_sub, which is an active-high select.
  typedef struct packed {
    logic pc_cntn;
    logic pc_den;
    logic pc_din;
    logic mar_inn;
    logic ram_den;
    logic ram_inn;
    logic ir_inn;
    logic ir_den;
    logic a_inn;
    logic a_den;
    logic b_inn;
    logic alu_den;
    logic alu_sub;
    logic out_inn;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    pc_cntn: 1'b1, pc_den: 1'b1, pc_din: 1'b1, mar_inn: 1'b1,
    ram_den: 1'b1, ram_inn: 1'b1, ir_inn: 1'b1, ir_den: 1'b1,
    a_inn:   1'b1, a_den:   1'b1, b_inn:  1'b1, alu_den: 1'b1,
    alu_sub: 1'b0, out_inn: 1'b1
  };

endpackage

// File: rtl/control_decode.sv
// Microcode ROM: {step, opcode, cf, zf} -> control word plus sequencing hints.
// Purely combinational, zero latency.
// No flow control; the top masks the word for HALT, enable and reset.
module control_decode
  import cpu_ctrl_pkg::*;
(
  input  step_t      step_i,
  input  logic [3:0] opcode_i,
  input  logic       cf_i,
  input  logic       zf_i,
  output ctrl_t      ctrl_o,
  output logic       last_o,
  output logic       flag_we_o,
  output logic       halt_req_o
);

`ifndef SEQ_COND_JUMP_EN
  // Flags only matter to conditional jumps, which decode as NOP here.
  logic unused_flags;
  assign unused_flags = cf_i ^ zf_i;
`endif

  // Microcode table; every data-moving step has exactly one bus driver.
  always_comb begin
    ctrl_o     = CTRL_IDLE;
    last_o     = 1'b0;
    flag_we_o  = 1'b0;
    halt_req_o = 1'b0;
    case (step_i)
      T0: begin
        ctrl_o.pc_den  = 1'b0;
        ctrl_o.mar_inn = 1'b0;
      end
      T1: begin
        ctrl_o.ram_den = 1'b0;
        ctrl_o.ir_inn  = 1'b0;
        ctrl_o.pc_cntn = 1'b0;
      end
      T2: begin
        case (opcode_i)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl_o.ir_den  = 1'b0;
            ctrl_o.mar_inn = 1'b0;
          end
          OP_LDI: begin
            ctrl_o.ir_den = 1'b0;
            ctrl_o.a_inn  = 1'b0;
            last_o        = 1'b1;
          end
          OP_JMP: begin
            ctrl_o.ir_den = 1'b0;
            ctrl_o.pc_din = 1'b0;
            last_o        = 1'b1;
          end
`ifdef SEQ_COND_JUMP_EN
          OP_JC: begin
            if (cf_i) begin
              ctrl_o.ir_den = 1'b0;
              ctrl_o.pc_din = 1'b0;
            end
            last_o = 1'b1;
          end
          OP_JZ: begin
            if (zf_i) begin
              ctrl_o.ir_den = 1'b0;
              ctrl_o.pc_din = 1'b0;
            end
            last_o = 1'b1;
          end
`endif
          OP_OUT: begin
            ctrl_o.a_den   = 1'b0;
            ctrl_o.out_inn = 1'b0;
            last_o         = 1'b1;
          end
          OP_HLT: begin
            halt_req_o = 1'b1;
            last_o     = 1'b1;
          end
          default: last_o = 1'b1;
        endcase
      end
      T3: begin
        case (opcode_i)
          OP_LDA: begin
            ctrl_o.ram_den = 1'b0;
            ctrl_o.a_inn   = 1'b0;
            last_o         = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl_o.ram_den = 1'b0;
            ctrl_o.b_inn   = 1'b0;
          end
          OP_STA: begin
            ctrl_o.a_den   = 1'b0;
            ctrl_o.ram_inn = 1'b0;
            last_o         = 1'b1;
          end
          default: last_o = 1'b1;
        endcase
      end
      T4: begin
        if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
          ctrl_o.alu_den = 1'b0;
          ctrl_o.a_inn   = 1'b0;
          ctrl_o.alu_sub = (opcode_i == OP_SUB);
          flag_we_o      = 1'b1;
        end
        last_o = 1'b1;
      end
      default: last_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute controller driving all bus strobes; optional SEQ_COND_JUMP_EN adds JC/JZ + flags.
// Strobes are combinational from current state; state advances one microstep per enabled cycle.
// i_en low freezes state and idles strobes; reset, HALT or PC overflow in T0 also idle them.
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [7:0] i_instr,
  input  logic       i_carry,
  input  logic       i_zero,
  input  logic       i_pc_overflow,
  output logic       o_pc_cntn,
  output logic       o_pc_den,
  output logic       o_pc_din,
  output logic       o_mar_inn,
  output logic       o_ram_den,
  output logic       o_ram_inn,
  output logic       o_ir_inn,
  output logic       o_ir_den,
  output logic       o_a_inn,
  output logic       o_a_den,
  output logic       o_b_inn,
  output logic       o_alu_den,
  output logic       o_alu_sub,
  output logic       o_out_inn,
  output logic       o_halt,
  output logic [2:0] o_step
);

  step_t step_q, step_d;
  mode_t mode_q, mode_d;
  logic  cf_dec, zf_dec;

  ctrl_t dec_ctrl;
  ctrl_t ctrl;
  logic  dec_last, dec_flag_we, dec_halt_req;
  logic  running, overflow_stop;

`ifdef SEQ_COND_JUMP_EN
  logic cf_q, cf_d, zf_q, zf_d;
  assign cf_dec = cf_q;
  assign zf_dec = zf_q;
  logic unused_ok;
  assign unused_ok = ^i_instr[3:0];
`else
  assign cf_dec = 1'b0;
  assign zf_dec = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{i_instr[3:0], i_carry, i_zero, dec_flag_we};
`endif

  control_decode u_decode (
    .step_i     (step_q),
    .opcode_i   (i_instr[7:4]),
    .cf_i       (cf_dec),
    .zf_i       (zf_dec),
    .ctrl_o     (dec_ctrl),
    .last_o     (dec_last),
    .flag_we_o  (dec_flag_we),
    .halt_req_o (dec_halt_req)
  );

  assign running       = i_en && (mode_q == MODE_RUN);
  assign overflow_stop = (step_q == T0) && i_pc_overflow;

  // State register: step, mode and (optionally) ALU flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      step_q <= T0;
      mode_q <= MODE_RUN;
`ifdef SEQ_COND_JUMP_EN
      cf_q   <= 1'b0;
      zf_q   <= 1'b0;
`endif
    end else begin
      step_q <= step_d;
      mode_q <= mode_d;
`ifdef SEQ_COND_JUMP_EN
      cf_q   <= cf_d;
      zf_q   <= zf_d;
`endif
    end
  end

  // Next state: advance a microstep, wrap on the last one, enter HALT on request or overflow.
  always_comb begin
    step_d = step_q;
    mode_d = mode_q;
`ifdef SEQ_COND_JUMP_EN
    cf_d   = cf_q;
    zf_d   = zf_q;
`endif
    if (running) begin
      if (overflow_stop) begin
        mode_d = MODE_HALT;
      end else if (dec_last) begin
        step_d = T0;
        if (dec_halt_req) mode_d = MODE_HALT;
`ifdef SEQ_COND_JUMP_EN
        if (dec_flag_we) begin
          cf_d = i_carry;
          zf_d = i_zero;
        end
`endif
      end else begin
        step_d = step_t'(step_q + 3'd1);
      end
    end
  end

  // Outputs: decoded word only while running; reset, stall, HALT and overflow idle the bus.
  always_comb begin
    ctrl = CTRL_IDLE;
    if (running && !i_rst && !overflow_stop) ctrl = dec_ctrl;
    o_pc_cntn = ctrl.pc_cntn;
    o_pc_den  = ctrl.pc_den;
    o_pc_din  = ctrl.pc_din;
    o_mar_inn = ctrl.mar_inn;
    o_ram_den = ctrl.ram_den;
    o_ram_inn = ctrl.ram_inn;
    o_ir_inn  = ctrl.ir_inn;
    o_ir_den  = ctrl.ir_den;
    o_a_inn   = ctrl.a_inn;
    o_a_den   = ctrl.a_den;
    o_b_inn   = ctrl.b_inn;
    o_alu_den = ctrl.alu_den;
    o_alu_sub = ctrl.alu_sub;
    o_out_inn = ctrl.out_inn;
    o_halt    = (mode_q == MODE_HALT);
    o_step    = step_q;
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: vector table, corner sequences, random vs model.
// Inputs change just after the falling edge; outputs are checked 1 time unit later.
// Strobe sets are compared as active-high "asserted" masks.
module tb_control_sequencer;

  logic       i_clk, i_rst, i_en, i_carry, i_zero, i_pc_overflow;
  logic [7:0] i_instr;
  logic o_pc_cntn, o_pc_den, o_pc_din, o_mar_inn, o_ram_den, o_ram_inn, o_ir_inn;
  logic o_ir_den, o_a_inn, o_a_den, o_b_inn, o_alu_den, o_alu_sub, o_out_inn, o_halt;
  logic [2:0] o_step;

  control_sequencer dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_instr(i_instr),
    .i_carry(i_carry), .i_zero(i_zero), .i_pc_overflow(i_pc_overflow),
    .o_pc_cntn(o_pc_cntn), .o_pc_den(o_pc_den), .o_pc_din(o_pc_din),
    .o_mar_inn(o_mar_inn), .o_ram_den(o_ram_den), .o_ram_inn(o_ram_inn),
    .o_ir_inn(o_ir_inn), .o_ir_den(o_ir_den), .o_a_inn(o_a_inn),
    .o_a_den(o_a_den), .o_b_inn(o_b_inn), .o_alu_den(o_alu_den),
    .o_alu_sub(o_alu_sub), .o_out_inn(o_out_inn), .o_halt(o_halt),
    .o_step(o_step)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

`ifdef SEQ_COND_JUMP_EN
  localparam bit CJ = 1'b1;
`else
  localparam bit CJ = 1'b0;
`endif

  localparam logic [13:0] PC_CNT  = 14'h0001;
  localparam logic [13:0] PC_DE   = 14'h0002;
  localparam logic [13:0] PC_DI   = 14'h0004;
  localparam logic [13:0] MAR_IN  = 14'h0008;
  localparam logic [13:0] RAM_DE  = 14'h0010;
  localparam logic [13:0] RAM_IN  = 14'h0020;
  localparam logic [13:0] IR_IN   = 14'h0040;
  localparam logic [13:0] IR_DE   = 14'h0080;
  localparam logic [13:0] A_IN    = 14'h0100;
  localparam logic [13:0] A_DE    = 14'h0200;
  localparam logic [13:0] B_IN    = 14'h0400;
  localparam logic [13:0] ALU_DE  = 14'h0800;
  localparam logic [13:0] ALU_SUB = 14'h1000;
  localparam logic [13:0] OUT_IN  = 14'h2000;
  localparam logic [13:0] DEN_MASK = PC_DE | RAM_DE | IR_DE | A_DE | ALU_DE;
  localparam logic [13:0] F0 = PC_DE | MAR_IN;
  localparam logic [13:0] F1 = RAM_DE | IR_IN | PC_CNT;
  localparam logic [13:0] NONE = 14'h0000;

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [13:0] asserted();
    return {~o_out_inn, o_alu_sub, ~o_alu_den, ~o_b_inn, ~o_a_den, ~o_a_inn,
            ~o_ir_den, ~o_ir_inn, ~o_ram_inn, ~o_ram_den, ~o_mar_inn,
            ~o_pc_din, ~o_pc_den, ~o_pc_cntn};
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // Check the current cycle (inputs already driven), then advance to the next falling edge.
  task automatic cyc(input string nm, input logic [13:0] exp_s, input int exp_step, input bit exp_halt);
    #1;
    chk({nm, "/strobes"}, int'(asserted()), int'(exp_s));
    chk({nm, "/step"}, int'(o_step), exp_step);
    chk({nm, "/halt"}, int'(o_halt), int'(exp_halt));
    chk({nm, "/bus"}, int'($countones(asserted() & DEN_MASK) <= 1), 1);
    @(negedge i_clk);
  endtask

  // Reset held one edge; checks that reset dominates an asserted enable.
  task automatic do_reset();
    i_rst = 1'b1; i_en = 1'b1; i_pc_overflow = 1'b0;
    @(negedge i_clk);
    cyc("reset", NONE, 0, 1'b0);
    i_rst = 1'b0;
  endtask

  // Reference: the full per-cycle strobe list of one instruction, from the opcode table.
  function automatic void build(input logic [3:0] op, input logic cf, input logic zf,
                                output logic [4:0][13:0] seq, output int len);
    seq = '0;
    seq[0] = F0;
    seq[1] = F1;
    len = 3;
    case (op)
      4'h1: begin seq[2] = IR_DE | MAR_IN; seq[3] = RAM_DE | A_IN; len = 4; end
      4'h2: begin seq[2] = IR_DE | MAR_IN; seq[3] = RAM_DE | B_IN; seq[4] = ALU_DE | A_IN; len = 5; end
      4'h3: begin seq[2] = IR_DE | MAR_IN; seq[3] = RAM_DE | B_IN; seq[4] = ALU_DE | A_IN | ALU_SUB; len = 5; end
      4'h4: begin seq[2] = IR_DE | MAR_IN; seq[3] = A_DE | RAM_IN; len = 4; end
      4'h5: seq[2] = IR_DE | A_IN;
      4'h6: seq[2] = IR_DE | PC_DI;
      4'h7: if (CJ && cf) seq[2] = IR_DE | PC_DI;
      4'h8: if (CJ && zf) seq[2] = IR_DE | PC_DI;
      4'hE: seq[2] = A_DE | OUT_IN;
      default: ;
    endcase
  endfunction

  typedef struct {
    logic [7:0]  instr;
    logic        carry;
    logic        zero;
    int          len;
    logic [13:0] e2, e3, e4;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [13:0] exp_s;
    logic [4:0][13:0] seq;
    int len, pos;
    logic m_cf, m_zf;
    logic [3:0] op;

    tbl[0]  = '{8'h00, 1'b0, 1'b0, 3, NONE, NONE, NONE};
    tbl[1]  = '{8'h15, 1'b0, 1'b0, 4, IR_DE | MAR_IN, RAM_DE | A_IN, NONE};
    tbl[2]  = '{8'h2A, 1'b1, 1'b0, 5, IR_DE | MAR_IN, RAM_DE | B_IN, ALU_DE | A_IN};
    tbl[3]  = '{8'h73, 1'b0, 1'b0, 3, CJ ? (IR_DE | PC_DI) : NONE, NONE, NONE};
    tbl[4]  = '{8'h83, 1'b0, 1'b1, 3, NONE, NONE, NONE};
    tbl[5]  = '{8'h31, 1'b0, 1'b1, 5, IR_DE | MAR_IN, RAM_DE | B_IN, ALU_DE | A_IN | ALU_SUB};
    tbl[6]  = '{8'h73, 1'b1, 1'b0, 3, NONE, NONE, NONE};
    tbl[7]  = '{8'h83, 1'b0, 1'b0, 3, CJ ? (IR_DE | PC_DI) : NONE, NONE, NONE};
    tbl[8]  = '{8'h47, 1'b0, 1'b0, 4, IR_DE | MAR_IN, A_DE | RAM_IN, NONE};
    tbl[9]  = '{8'h59, 1'b0, 1'b0, 3, IR_DE | A_IN, NONE, NONE};
    tbl[10] = '{8'h6C, 1'b0, 1'b0, 3, IR_DE | PC_DI, NONE, NONE};
    tbl[11] = '{8'hE0, 1'b0, 1'b0, 3, A_DE | OUT_IN, NONE, NONE};
    tbl[12] = '{8'h9B, 1'b0, 1'b0, 3, NONE, NONE, NONE};
    tbl[13] = '{8'hD4, 1'b0, 1'b0, 3, NONE, NONE, NONE};

    i_rst = 1'b0; i_en = 1'b0; i_instr = 8'h00;
    i_carry = 1'b0; i_zero = 1'b0; i_pc_overflow = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_en = 1'b0;
    i_rst = 1'b0;
    cyc("reset_idle", NONE, 0, 1'b0);

    // Vector table, run back to back so flags carry between entries.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      i_instr = tbl[i].instr; i_carry = tbl[i].carry; i_zero = tbl[i].zero; i_en = 1'b1;
      for (int s = 0; s < tbl[i].len; s++) begin
        exp_s = (s == 0) ? F0 : (s == 1) ? F1 : (s == 2) ? tbl[i].e2 : (s == 3) ? tbl[i].e3 : tbl[i].e4;
        cyc($sformatf("tbl%0d_T%0d", i, s), exp_s, s, 1'b0);
      end
    end
    cyc("tbl_wrap", F0, 0, 1'b0);

    // Enable dropped in LDA T2 for three cycles, then resumed.
    do_reset();
    i_instr = 8'h15; i_en = 1'b1;
    cyc("en_T0", F0, 0, 1'b0);
    cyc("en_T1", F1, 1, 1'b0);
    i_en = 1'b0;
    for (int k = 0; k < 3; k++) cyc($sformatf("en_stall%0d", k), NONE, 2, 1'b0);
    i_en = 1'b1;
    cyc("en_T2", IR_DE | MAR_IN, 2, 1'b0);
    cyc("en_T3", RAM_DE | A_IN, 3, 1'b0);
    cyc("en_next", F0, 0, 1'b0);

    // Reset asserted during ADD T3 abandons the instruction.
    do_reset();
    i_instr = 8'h2A; i_en = 1'b1;
    cyc("rst_T0", F0, 0, 1'b0);
    cyc("rst_T1", F1, 1, 1'b0);
    cyc("rst_T2", IR_DE | MAR_IN, 2, 1'b0);
    i_rst = 1'b1;
    cyc("rst_T3", NONE, 3, 1'b0);
    cyc("rst_after", NONE, 0, 1'b0);
    i_rst = 1'b0;
    cyc("rst_resume", F0, 0, 1'b0);

    // HLT: three cycles, then halted with idle bus until reset.
    do_reset();
    i_instr = 8'hF0; i_en = 1'b1;
    cyc("hlt_T0", F0, 0, 1'b0);
    cyc("hlt_T1", F1, 1, 1'b0);
    cyc("hlt_T2", NONE, 2, 1'b0);
    for (int k = 0; k < 20; k++) begin
      i_en = ($urandom_range(0, 3) != 0);
      i_instr = 8'($urandom);
      cyc($sformatf("hlt_hold%0d", k), NONE, 0, 1'b1);
    end
    i_rst = 1'b1; i_en = 1'b1;
    cyc("hlt_rst", NONE, 0, 1'b1);
    i_rst = 1'b0; i_instr = 8'h00;
    cyc("hlt_released", F0, 0, 1'b0);
    cyc("hlt_rel_T1", F1, 1, 1'b0);
    cyc("hlt_rel_T2", NONE, 2, 1'b0);

    // PC overflow in T0 halts instead of fetching.
    i_pc_overflow = 1'b1;
    cyc("ovf_T0", NONE, 0, 1'b0);
    i_pc_overflow = 1'b0;
    cyc("ovf_halted", NONE, 0, 1'b1);
    cyc("ovf_stays", NONE, 0, 1'b1);

    // Random instructions and enable against the instruction-list model.
    do_reset();
    pos = 0; m_cf = 1'b0; m_zf = 1'b0; op = 4'h0;
    for (int n = 0; n < 1500; n++) begin
      if (pos == 0) begin
        i_instr = 8'($urandom);
        if (i_instr[7:4] == 4'hF) i_instr[7:4] = 4'h2;
        op = i_instr[7:4];
      end
      i_en = ($urandom_range(0, 4) != 0);
      i_carry = 1'($urandom);
      i_zero = 1'($urandom);
      build(op, m_cf, m_zf, seq, len);
      cyc($sformatf("rnd%0d_op%0h", n, op), i_en ? seq[pos] : NONE, pos, 1'b0);
      if (i_en) begin
        if (pos == len - 1) begin
          if (CJ && (op == 4'h2 || op == 4'h3)) begin
            m_cf = i_carry;
            m_zf = i_zero;
          end
          pos = 0;
        end else begin
          pos++;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
